// File: rtl/uart_register_controller_pkg.sv
// uart_register_controller_pkg: shared packet type, controller states and command lengths
package uart_register_controller_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        WRITE,
        READ,
        READ_WAIT,
        TRANSMIT
    } ctrl_state_t;

    localparam int         DATA_WIDTH_DEFAULT = 32;
    localparam logic [7:0] CMD_LEN_READ       = 8'd1;
    localparam logic [7:0] CMD_LEN_WRITE      = 8'(1 + DATA_WIDTH_DEFAULT / 8);

endpackage

// File: rtl/uart_register_controller_packet_byte_serialiser.sv
// packet_byte_serialiser: emits {address, data} as a framed byte packet under valid/ready
module packet_byte_serialiser
    import uart_register_controller_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] LOCAL_ADDR = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [7:0]            destination,
    input  logic [DATA_WIDTH+7:0] payload,
    input  logic                  ready,
    output UART_PACKET            stream,
    output logic                  done
);

    localparam int         BYTES = DATA_WIDTH / 8;
    localparam logic [7:0] LAST  = 8'(BYTES);

    logic [DATA_WIDTH-1:0] rest;
    logic [7:0]            idx;

    assign done = stream.Valid && ready && stream.EoP;

    // Present one byte at a time; the held byte only advances once accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stream <= '0;
            rest   <= '0;
            idx    <= '0;
        end else if (load) begin
            stream <= '{Source: LOCAL_ADDR, Destination: destination, Length: 8'(1 + BYTES),
                        SoP: 1'b1, EoP: 1'b0, Data: payload[7:0], Valid: 1'b1};
            rest   <= payload[8 +: DATA_WIDTH];
            idx    <= 8'd1;
        end else if (stream.Valid && ready) begin
            if (stream.EoP) begin
                stream <= '0;
            end else begin
                stream.Data <= rest[7:0];
                stream.SoP  <= 1'b0;
                stream.EoP  <= idx == LAST;
                rest        <= rest >> 8;
                idx         <= idx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/uart_register_controller.sv
// uart_register_controller: decodes UART command packets into register writes/reads and returns read responses
module uart_register_controller
    import uart_register_controller_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] LOCAL_ADDR = 8'h00
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  UART_PACKET            ipRxStream,
    output UART_PACKET            opTxStream,
    input  logic                  ipTxReady,
    output logic [7:0]            opAddress,
    output logic [DATA_WIDTH-1:0] opWrData,
    output logic                  opWrEnable,
    input  logic [DATA_WIDTH-1:0] ipRdData,
    output logic                  opBusy,
    output logic [7:0]            opErrorCount
);

    localparam int         BYTES = DATA_WIDTH / 8;
    localparam logic [7:0] LEN_W = 8'(1 + BYTES);
    localparam int         BUF_W = 8 * (1 + BYTES);

    ctrl_state_t      state;
    logic [7:0]       cnt, len, src;
    logic [BUF_W-1:0] buffer, buf_next;
    logic             sop_any, start, take, good, load, done;
    logic [7:0]       byte_idx, cur_len, new_cnt;
    logic [1:0]       incr;
    logic [8:0]       err_sum;

    assign opBusy = !(state == IDLE || state == RECEIVE);
    assign load   = state == READ_WAIT;

    // Classify the incoming byte against the reception in progress and tally errors
    always_comb begin
        sop_any  = ipRxStream.Valid && ipRxStream.SoP;
        start    = sop_any && ipRxStream.Destination == LOCAL_ADDR;
        take     = (state == IDLE && start) ||
                   (state == RECEIVE && ipRxStream.Valid && (!ipRxStream.SoP || start));
        byte_idx = start ? 8'd0 : cnt;
        cur_len  = start ? ipRxStream.Length : len;
        new_cnt  = byte_idx == 8'hFF ? 8'hFF : byte_idx + 8'd1;
        good     = (cur_len == CMD_LEN_READ || cur_len == LEN_W) && new_cnt == cur_len;
        buf_next = buffer;
        for (int i = 0; i < 1 + BYTES; i++)
            if (byte_idx == 8'(i)) buf_next[i*8 +: 8] = ipRxStream.Data;
        incr     = 2'(state == RECEIVE && sop_any) + 2'(take && ipRxStream.EoP && !good) +
                   2'(opBusy && start);
        err_sum  = {1'b0, opErrorCount} + {7'd0, incr};
    end

    // Command sequencer owning the register-file address, data and write strobe
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            src          <= '0;
            buffer       <= '0;
            opAddress    <= '0;
            opWrData     <= '0;
            opWrEnable   <= 1'b0;
            opErrorCount <= '0;
        end else begin
            opWrEnable   <= 1'b0;
            opErrorCount <= err_sum[8] ? 8'hFF : err_sum[7:0];
            case (state)
                IDLE, RECEIVE: begin
                    if (take) begin
                        buffer <= buf_next;
                        cnt    <= new_cnt;
                        len    <= cur_len;
                        if (start) src <= ipRxStream.Source;
                        if (!ipRxStream.EoP) begin
                            state <= RECEIVE;
                        end else if (!good) begin
                            state <= IDLE;
                        end else begin
                            opAddress <= buf_next[7:0];
                            if (cur_len == CMD_LEN_READ) begin
                                state <= READ;
                            end else begin
                                opWrData   <= buf_next[8 +: DATA_WIDTH];
                                opWrEnable <= 1'b1;
                                state      <= WRITE;
                            end
                        end
                    end else if (state == RECEIVE && sop_any) begin
                        state <= IDLE;
                    end
                end
                WRITE:     state <= IDLE;
                READ:      state <= READ_WAIT;
                READ_WAIT: state <= TRANSMIT;
                TRANSMIT:  if (done) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    packet_byte_serialiser #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOCAL_ADDR (LOCAL_ADDR)
    ) u_ser (
        .clk         (ipClk),
        .rst         (ipReset),
        .load        (load),
        .destination (src),
        .payload     ({ipRdData, opAddress}),
        .ready       (ipTxReady),
        .stream      (opTxStream),
        .done        (done)
    );

endmodule

// File: doc/uart_register_controller.md
# uart_register_controller

Command sequencer between the UART packet layer and the register file. Accepts command packets from the receive packet stream, decodes them into register-file writes or reads, and for reads builds and transmits a response packet through the transmit packet stream with ready/valid back-pressure. It replaces the separate transmit-side and receive-side glue with a single owner of the register-file address, write-data and write-enable signals.

## Interface

- DATA_WIDTH, 32: register width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
- LOCAL_ADDR, 8'h00: packet address of this node.

- ipClk  in  1  system clock, all logic on rising edge
- ipReset  in  1  reset; asynchronous, active-high
- ipRxStream  in  UART_PACKET  received byte stream: Source, Destination, Length[7:0], SoP, EoP, Data[7:0], Valid; no back-pressure
- opTxStream  out  UART_PACKET  transmit byte stream, same fields
- ipTxReady  in  1  packet layer accepts the byte when opTxStream.Valid && ipTxReady
- opAddress  out  8  register address
- opWrData  out  DATA_WIDTH  register write data
- opWrEnable  out  1  one-cycle write strobe
- ipRdData  in  DATA_WIDTH  register read data, valid one cycle after opAddress changes
- opBusy  out  1  high in any state other than IDLE/RECEIVE
- opErrorCount  out  8  saturating count of discarded packets

## Operation

- Command packet: Destination == LOCAL_ADDR. Byte 0 is the register address.
  - Write: Length == 1+BYTES; bytes 1..BYTES are data, little-endian.
  - Read: Length == 1.
- Other Destination: packet ignored silently; not counted.
- States:
  - IDLE: SoP with matching Destination -> RECEIVE.
  - RECEIVE: bytes shift into the buffer and a byte counter increments.
  - EoP with the counter matching Length and a legal Length -> WRITE or READ.
  - Any other EoP -> error, IDLE.
  - WRITE: opWrEnable = 1 for one cycle -> IDLE.
  - READ: opAddress driven -> READ_WAIT.
  - READ_WAIT: ipRdData captured -> TRANSMIT.
  - TRANSMIT: emits 1+BYTES bytes.
    - Header: Source = LOCAL_ADDR, Destination = the command's Source, Length = 1+BYTES.
    - Payload: address, then data little-endian.
    - SoP on the first byte, EoP on the last; after the last accept -> IDLE.
- Errors increment opErrorCount, saturating at 8'hFF:
  - illegal Length;
  - EoP before Length bytes;
  - more bytes than Length (discard until EoP);
  - Valid bytes arriving while opBusy (packet dropped, counted once per SoP).
- SoP during RECEIVE: current packet counted as an error; new packet restarts reception.
- Single-byte packet: SoP and EoP on the same byte is legal (read command).
- Reset, including mid-operation: state IDLE; all outputs 0; opTxStream all fields 0; buffer and counters cleared; a partial transmit is abandoned without EoP.

## Timing

- Rx EoP accepted in cycle N:
  - Write: opAddress/opWrData valid from N+1, opWrEnable high in N+1 only.
  - Read: opAddress valid in N+1, ipRdData sampled at the end of N+2, first Tx byte Valid in N+3.
- opAddress and opWrData hold their last value until the next command.
- Tx bytes: Valid and all fields stay stable until accepted; back-to-back bytes when ipTxReady is held high.
- Minimum read turnaround with ipTxReady tied high: EoP to response EoP = 3 + BYTES cycles.
- Back-to-back commands: a write command may begin with SoP in N+2 after the previous write's EoP; no bytes are lost.

## Structure

- Shared package holds:
  - UART_PACKET typedef;
  - controller state enum;
  - CMD_LEN_READ = 1 and CMD_LEN_WRITE = 1+BYTES.
- One sub-module, packet_byte_serialiser: loads {address, data} and shifts bytes out under the Valid/Ready handshake, generating SoP/EoP.

## Test plan

- Write: packet to LOCAL_ADDR, Length 5, bytes 03 78 56 34 12 -> opWrEnable one cycle, opAddress 03, opWrData 32'h12345678; no Tx.
- Read: Source 22, Length 1, byte 03, ipRdData 32'hCAFEF00D -> Tx Destination 22, Length 5, bytes 03 0D F0 FE CA, SoP on byte 1, EoP on byte 5.
- Back-pressure: ipTxReady toggling 1-0-0-1 during the read response -> identical byte sequence, fields stable while stalled.
- Malformed: Length 3 command; then Length 5 with EoP after 2 bytes -> no write, opErrorCount = 2.
- Busy drop: write command arriving during TRANSMIT with ipTxReady low -> dropped, opErrorCount + 1, response unaffected; foreign Destination packet -> no change.
- Reset asserted mid-TRANSMIT after 2 bytes -> all outputs 0 immediately; a following read command completes normally.
